serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port a  input  WIDTH  minuend/augend.
REQ-007 The block SHALL have port b  input  WIDTH  subtrahend/addend.
REQ-008 The block SHALL have port cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 The block SHALL have port busy  output  1  operation in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port sum  output  WIDTH  registered result.
REQ-013 The block SHALL have port cout  output  1  raw carry out of MSB digit.
REQ-014 The block SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL use an FSM with states IDLE and RUN.
REQ-016 In IDLE with start=1 at a clock edge, the block SHALL capture a, b, cin and sub, then enter RUN.
REQ-017 In RUN, the block SHALL process one DIGIT-bit slice per cycle, LSB slice first, for N = WIDTH/DIGIT cycles.
REQ-018 The block SHALL form each slice as a + (b XOR {DIGIT{sub}}) + carry.
REQ-019 The block SHALL register the carry between slices.
REQ-020 The initial carry SHALL be cin when sub=0 and NOT cin when sub=1, so the result is a+b+cin or a-b-cin modulo 2^WIDTH.
REQ-021 After the Nth slice, the block SHALL return to IDLE and assert done for exactly one cycle; start accepted at edge k SHALL give done=1 in the cycle after edge k+N.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 sum, cout and ovf SHALL update only on completion and SHALL hold until the next completion or reset.
REQ-024 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-025 start while busy=1 SHALL be ignored, and operands SHALL NOT be resampled.
REQ-026 start in the done cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-027 Input changes during RUN SHALL have no effect on the result.

Reset
REQ-028 rst=1 SHALL immediately force IDLE with busy=0, done=0, sum=0, cout=0, ovf=0 and all internal registers cleared.
REQ-029 Reset during RUN SHALL abort the operation, and no done SHALL follow.

Configuration
REQ-030 With macro ADDSUB_SAT_EN defined, the block SHALL clamp the result when ovf=1: sum SHALL be the most-positive value (0x7FFF for WIDTH=16) if the true result is positive and the most-negative value (0x8000) if negative, with ovf still 1.
REQ-031 With ADDSUB_SAT_EN undefined, the block SHALL wrap the result modulo 2^WIDTH and SHALL contain no clamp logic.

Structure
REQ-032 Package addsub_pkg SHALL hold the FSM state typedef (IDLE, RUN) and the default WIDTH/DIGIT constants.
REQ-033 Sub-module addsub_digit SHALL be a combinational DIGIT-bit ripple slice built from per-bit full-adder cells with a sub-controlled b inversion, with outputs slice sum, carry out and MSB carry-in; serial_addsub SHALL instantiate it once.

Verification (WIDTH=16, DIGIT=4)
REQ-034 Add 0x1234 + 0x0FFF, cin=0 -> sum=0x2233, cout=0, ovf=0, done 4 cycles after the start edge, busy high for 4 cycles.
REQ-035 Add 0x7FFF + 0x0001 -> ovf=1; sum=0x8000 without ADDSUB_SAT_EN, 0x7FFF with it.
REQ-036 Subtract 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; subtract 0x0007 - 0x0005, cin=1 -> sum=0x0001, cout=1.
REQ-037 Assert rst in the 2nd RUN cycle -> busy=0, sum=0 immediately, and no done pulse afterwards.
REQ-038 Pulse start again mid-RUN with different operands -> the first result is unchanged; start in the done cycle -> the second result arrives exactly N cycles later.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the digit-serial adder/subtractor.
package addsub_pkg;

  // Defaults: 16-bit operands processed four bits per cycle.
  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDigit = 4;

  // Control FSM: waiting for a request, or stepping through the slices.
  typedef enum logic {
    Idle = 1'b0,
    Run  = 1'b1
  } state_t;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice. It is built from per-bit full-adder cells.
// When sub is set, b is inverted so that the slice computes a + ~b + cin.
// It exports the carry into the MSB cell, which the caller uses for signed overflow.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int unsigned DIGIT = DefDigit
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] bx;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign bx[i]   = b[i] ^ sub;
    assign s[i]    = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. It handles one DIGIT-bit slice per cycle, LSB slice first.
// WIDTH must be an integer multiple of DIGIT.
// Optional feature macro: ADDSUB_SAT_EN. When it is defined, a result that overflows
// is clamped to the most-positive or most-negative signed value.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DIGIT = DefDigit
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, res_full, result_d;
  logic             sub_q, carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, done_q;

  logic             accept, last;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co, slice_cmsb;

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .s    (slice_s),
    .co   (slice_co),
    .cmsb (slice_cmsb)
  );

  assign accept = (state_q == Idle) && start;
  assign last   = (cnt_q == CntW'(N - 1));

  // Next FSM state: leave Idle on a request, return after the last slice.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (start) state_d = Run;
      Run:     if (last)  state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // Assemble the result. The new slice enters at the top, and earlier slices shift toward the LSB.
  always_comb begin
    res_full = (res_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
    result_d = res_full;
`ifdef ADDSUB_SAT_EN
    // A wrapped result has the wrong sign, so the true sign is the inverse of the wrapped MSB.
    if (slice_co ^ slice_cmsb) begin
      result_d = {~res_full[WIDTH-1], {(WIDTH-1){res_full[WIDTH-1]}}};
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= Idle;
    else     state_q <= state_d;
  end

  // Datapath: capture the operands on accept, step one slice per Run cycle, and publish on the last slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        // Subtraction is a + ~b + 1. A borrow-in removes that +1.
        carry_q <= sub ? ~cin : cin;
        cnt_q   <= '0;
        res_q   <= '0;
      end else if (state_q == Run) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= slice_co;
        res_q   <= res_full;
        cnt_q   <= cnt_q + 1'b1;
        if (last) begin
          sum_q  <= result_d;
          cout_q <= slice_co;
          ovf_q  <= slice_co ^ slice_cmsb;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == Run);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with WIDTH=16 and DIGIT=4. Optional feature macro: ADDSUB_SAT_EN.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call this task at a negedge. It launches one operation and checks the four busy cycles.
  // It then checks the results in the done cycle and returns at that done-cycle negedge.
  // When disturb is set, the task drives a spurious start and new operands during the run.
  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                    input logic tcin, input logic tsub, input bit disturb,
                    input logic [15:0] es, input logic ec, input logic eo);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      if (disturb && i == 1) begin
        start = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = ~cin; sub = ~sub;
      end
      if (disturb && i == 2) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    logic [15:0] sat_pos, sat_neg;
`ifdef ADDSUB_SAT_EN
    sat_pos = 16'h7FFF;
    sat_neg = 16'h8000;
`else
    sat_pos = 16'h8000;
    sat_neg = 16'h7FFF;
`endif

    // Check the outputs while reset is held.
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic add, then confirm that the result holds while the inputs change with no start.
    op("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    @(negedge clk);
    check("add1_pulse", 32'(done), 32'd0);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_sum", 32'(sum), 32'h2233);
    check("hold_busy", 32'(busy), 32'd0);

    // Positive overflow.
    op("ovfp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, sat_pos, 1'b0, 1'b1);
    @(negedge clk);

    // Negative overflow on subtract. The next three operations start back-to-back in each done cycle.
    op("ovfn", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, sat_neg, 1'b1, 1'b1);
    op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op("sub2", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    op("addc", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    // A mid-run start and operand changes must not affect this result. The next operation then starts back-to-back.
    op("mid", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
    op("b2b", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_pulse", 32'(done), 32'd0);

    // Reset in the second Run cycle.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_nodone", 32'(seen_done), 32'd0);
    check("abort_sum_after", 32'(sum), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
